// File: rtl/ad9912_cmd_arbiter.sv
// Shares one AD9912 driver command port between a pulse-program requester (pp) and a
// lock/servo requester (lock); each owns a one-deep slot, lock has capped fixed priority.
module ad9912_cmd_arbiter #(
  parameter int CMD_WIDTH       = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int TIMEOUT_WIDTH   = 13,
  parameter int LOCK_MAX_CONSEC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CMD_WIDTH-1:0]  pp_cmd,
  input  logic [DATA_WIDTH-1:0] pp_data,
  input  logic                  pp_valid,
  output logic                  pp_busy,
  output logic                  pp_ack,
  input  logic [CMD_WIDTH-1:0]  lock_cmd,
  input  logic [DATA_WIDTH-1:0] lock_data,
  input  logic                  lock_valid,
  output logic                  lock_busy,
  output logic                  lock_ack,
  output logic [CMD_WIDTH-1:0]  dds_cmd,
  output logic [DATA_WIDTH-1:0] dds_data,
  output logic                  dds_ready,
  input  logic                  dds_done,
  output logic                  grant_lock,
  output logic                  active,
  input  logic                  clear_errors,
  output logic                  err_timeout,
  output logic [1:0]            err_overflow
);

  localparam int CNT_W = $clog2(LOCK_MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(LOCK_MAX_CONSEC);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic [CNT_W-1:0]        consec;

  logic [CMD_WIDTH-1:0]    pp_cmd_q;
  logic [DATA_WIDTH-1:0]   pp_data_q;
  logic [CMD_WIDTH-1:0]    lock_cmd_q;
  logic [DATA_WIDTH-1:0]   lock_data_q;

  logic grant;
  logic pick_pp;
  logic xfer_done;
  logic xfer_abort;
  logic pp_free;
  logic lock_free;
  logic pp_load;
  logic lock_load;

  // Next-state and per-edge decisions
  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    pick_pp    = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (pp_busy || lock_busy) begin
          grant    = 1'b1;
          pick_pp  = pp_busy && (!lock_busy || (consec == CONSEC_MAX));
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (dds_done) begin
          xfer_done = 1'b1;
          state_nx  = S_IDLE;
        end else if (timer == TIMER_LAST) begin
          xfer_abort = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // A slot freed on this edge may be refilled on the same edge.
  assign pp_free   = (xfer_done || xfer_abort) && !grant_lock;
  assign lock_free = (xfer_done || xfer_abort) &&  grant_lock;
  assign pp_load   = pp_valid   && (!pp_busy   || pp_free);
  assign lock_load = lock_valid && (!lock_busy || lock_free);
  assign active    = (state == S_ISSUE) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      if (state == S_ISSUE) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dds_cmd    <= '0;
      dds_data   <= '0;
      dds_ready  <= 1'b0;
      grant_lock <= 1'b0;
      pp_ack     <= 1'b0;
      lock_ack   <= 1'b0;
    end else begin
      dds_ready <= grant;
      pp_ack    <= xfer_done && !grant_lock;
      lock_ack  <= xfer_done &&  grant_lock;
      if (grant) begin
        grant_lock <= !pick_pp;
        dds_cmd    <= pick_pp ? pp_cmd_q  : lock_cmd_q;
        dds_data   <= pick_pp ? pp_data_q : lock_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pp_busy     <= 1'b0;
      pp_cmd_q    <= '0;
      pp_data_q   <= '0;
      lock_busy   <= 1'b0;
      lock_cmd_q  <= '0;
      lock_data_q <= '0;
    end else begin
      if (pp_load) begin
        pp_busy   <= 1'b1;
        pp_cmd_q  <= pp_cmd;
        pp_data_q <= pp_data;
      end else if (pp_free) begin
        pp_busy <= 1'b0;
      end
      if (lock_load) begin
        lock_busy   <= 1'b1;
        lock_cmd_q  <= lock_cmd;
        lock_data_q <= lock_data;
      end else if (lock_free) begin
        lock_busy <= 1'b0;
      end
    end
  end

  // Streak of lock grants taken while pp is waiting; saturates at the cap.
  always_ff @(posedge clk) begin
    if (rst) begin
      consec <= '0;
    end else if (!pp_busy || (grant && pick_pp)) begin
      consec <= '0;
    end else if (grant && (consec != CONSEC_MAX)) begin
      consec <= consec + 1'b1;
    end
  end

  // Sticky errors: a set on the same edge as a clear survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout  <= 1'b0;
      err_overflow <= 2'b00;
    end else begin
      err_timeout     <= (err_timeout     && !clear_errors) || xfer_abort;
      err_overflow[0] <= (err_overflow[0] && !clear_errors) || (pp_valid   && !pp_load);
      err_overflow[1] <= (err_overflow[1] && !clear_errors) || (lock_valid && !lock_load);
    end
  end

endmodule
